// File: rtl/slice_cfg_loader.sv
// slice_cfg_loader: framed 32-bit word stream -> atomically committed slice LUT INIT / MUX_CFG (SLICE_CFG_CHECK_EN adds XOR checksum word)
module slice_cfg_loader (
  input  logic        CLK,
  input  logic        SR_N,
  input  logic [31:0] CFG_DATA,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  output logic [63:0] ALUT_INIT,
  output logic [63:0] BLUT_INIT,
  output logic [63:0] CLUT_INIT,
  output logic [63:0] DLUT_INIT,
  output logic [31:0] MUX_CFG,
  output logic        CFG_DONE,
  output logic        CFG_ERR,
  output logic        CFG_BUSY
);
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef SLICE_CFG_CHECK_EN
    CHECK,
`endif
    COMMIT
  } state_t;
  state_t state, state_nx;
  logic rdy_en, xfer, magic_ok, last, bad;
  logic [3:0] cnt;
  logic [4:0] mask;
  logic [3:0][1:0][31:0] lut_sh;
  logic [31:0] mux_sh, mux_q;
  logic [3:0][63:0] lut_q;
`ifdef SLICE_CFG_CHECK_EN
  logic [31:0] csum;
  logic sum_ok;
  assign sum_ok = CFG_DATA == csum;
`endif
  assign magic_ok = CFG_DATA[31:16] == 16'hC7F0;
  assign last = cnt == 4'd8;
  // rdy_en keeps READY low until the first edge out of reset
  assign CFG_READY = rdy_en && state != COMMIT;
  assign xfer = CFG_VALID && CFG_READY;
  assign CFG_BUSY = state != IDLE;
  assign {DLUT_INIT, CLUT_INIT, BLUT_INIT, ALUT_INIT} = lut_q;
  assign MUX_CFG = mux_q;
`ifdef SLICE_CFG_CHECK_EN
  assign bad = xfer && ((state == IDLE && !magic_ok) || (state == CHECK && !sum_ok));
`else
  assign bad = xfer && state == IDLE && !magic_ok;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = xfer && magic_ok ? LOAD : IDLE;
`ifdef SLICE_CFG_CHECK_EN
      LOAD:   state_nx = xfer && last ? CHECK : LOAD;
      CHECK:  state_nx = xfer ? (sum_ok ? COMMIT : IDLE) : CHECK;
`else
      LOAD:   state_nx = xfer && last ? COMMIT : LOAD;
`endif
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!SR_N) begin
      state    <= IDLE;
      rdy_en   <= 1'b0;
      cnt      <= '0;
      mask     <= '0;
      lut_sh   <= '0;
      mux_sh   <= '0;
      lut_q    <= '0;
      mux_q    <= '0;
      CFG_DONE <= 1'b0;
      CFG_ERR  <= 1'b0;
`ifdef SLICE_CFG_CHECK_EN
      csum     <= '0;
`endif
    end else begin
      state    <= state_nx;
      rdy_en   <= 1'b1;
      CFG_DONE <= state == COMMIT;
      CFG_ERR  <= bad;
      if (xfer && state == IDLE && magic_ok) begin
        mask <= CFG_DATA[4:0];
        cnt  <= '0;
`ifdef SLICE_CFG_CHECK_EN
        csum <= CFG_DATA;
`endif
      end
      if (xfer && state == LOAD) begin
        if (last) mux_sh <= CFG_DATA;
        else lut_sh[cnt[2:1]][cnt[0]] <= CFG_DATA;
        cnt <= cnt + 4'd1;
`ifdef SLICE_CFG_CHECK_EN
        csum <= csum ^ CFG_DATA;
`endif
      end
      if (state == COMMIT) begin
        for (int i = 0; i < 4; i++) if (mask[i]) lut_q[i] <= lut_sh[i];
        if (mask[4]) mux_q <= mux_sh;
      end
    end
  end
endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb_slice_cfg_loader: directed frame vectors plus reset and back-to-back sequences for slice_cfg_loader
module tb_slice_cfg_loader;
`ifdef SLICE_CFG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [63:0] A0 = 64'h0000_0002_0000_0001;
  localparam logic [63:0] B0 = 64'h0000_0004_0000_0003;
  localparam logic [63:0] C0 = 64'h0000_0006_0000_0005;
  localparam logic [63:0] D0 = 64'h0000_0008_0000_0007;
  localparam logic [63:0] ON = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        CLK = 1'b0, SR_N = 1'b0, CFG_VALID = 1'b0;
  logic [31:0] CFG_DATA = '0;
  logic        CFG_READY, CFG_DONE, CFG_ERR, CFG_BUSY;
  logic [63:0] ALUT_INIT, BLUT_INIT, CLUT_INIT, DLUT_INIT;
  logic [31:0] MUX_CFG;
  int tests = 0, fails = 0;
  int low_cnt = 0, dn_cnt = 0;
  bit mon_en = 1'b0;
  logic [63:0] snap_b = '0;
  typedef struct {
    logic [31:0] hdr;
    logic        ones;
    logic [31:0] mw;
    logic        flip;
    logic [63:0] a, b, c, d;
    logic [31:0] m;
  } vec_t;
  vec_t v[7];
  slice_cfg_loader dut (
    .CLK(CLK), .SR_N(SR_N), .CFG_DATA(CFG_DATA), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .ALUT_INIT(ALUT_INIT), .BLUT_INIT(BLUT_INIT), .CLUT_INIT(CLUT_INIT), .DLUT_INIT(DLUT_INIT),
    .MUX_CFG(MUX_CFG), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .CFG_BUSY(CFG_BUSY)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (!CFG_READY) low_cnt++;
      if (CFG_DONE) begin
        dn_cnt++;
        if (dn_cnt == 1) snap_b = BLUT_INIT;
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic chk_outs(input string tag, input logic [63:0] a, b, c, d, input logic [31:0] m);
    chk({tag, " ALUT"}, ALUT_INIT, a);
    chk({tag, " BLUT"}, BLUT_INIT, b);
    chk({tag, " CLUT"}, CLUT_INIT, c);
    chk({tag, " DLUT"}, DLUT_INIT, d);
    chk({tag, " MUX"}, {32'd0, MUX_CFG}, {32'd0, m});
  endtask
  task automatic send(input logic [31:0] w, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
    CFG_DATA = w;
    CFG_VALID = 1'b1;
    n = 0;
    while (!CFG_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!CFG_READY) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got READY=0 expected READY=1 within 20 cycles");
    end
    @(posedge CLK);
    #1 CFG_VALID = 1'b0;
    CFG_DATA = '0;
  endtask
  task automatic send_frame(input logic [31:0] hdr, input logic [8:0][31:0] w, input logic flip, input bit gaps);
    logic [31:0] cs;
    cs = hdr;
    send(hdr, gaps);
    for (int i = 0; i < 9; i++) begin
      send(w[i], gaps);
      cs ^= w[i];
    end
    if (CHK) send(cs ^ {31'd0, flip}, gaps);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
  initial begin
    logic [8:0][31:0] w;
    v[0] = '{32'hC7F0_001F, 1'b0, 32'hA5A5_0003, 1'b0, A0, B0, C0, D0, 32'hA5A5_0003};
    v[1] = '{32'hC7F0_0004, 1'b1, 32'hFFFF_FFFF, 1'b0, A0, B0, ON, D0, 32'hA5A5_0003};
    v[2] = '{32'h1234_000F, 1'b0, 32'h0,         1'b0, A0, B0, ON, D0, 32'hA5A5_0003};
    v[3] = '{32'hC7F0_0010, 1'b0, 32'h0000_BEEF, 1'b0, A0, B0, ON, D0, 32'h0000_BEEF};
    v[4] = '{32'hC7F0_0000, 1'b1, 32'h1,         1'b0, A0, B0, ON, D0, 32'h0000_BEEF};
    v[5] = '{32'hC7F0_0003, 1'b1, 32'h0,         1'b1, A0, B0, ON, D0, 32'h0000_BEEF};
    v[6] = '{32'hC7F0_000B, 1'b1, 32'h0,         1'b0, ON, ON, ON, ON, 32'h0000_BEEF};
    repeat (3) @(posedge CLK);
    #1;
    chk("rst READY", {63'd0, CFG_READY}, 64'd0);
    chk("rst BUSY", {63'd0, CFG_BUSY}, 64'd0);
    chk("rst DONE", {63'd0, CFG_DONE}, 64'd0);
    chk("rst ERR", {63'd0, CFG_ERR}, 64'd0);
    chk_outs("rst", '0, '0, '0, '0, '0);
    SR_N = 1'b1;
    @(posedge CLK);
    #1 chk("post-rst READY", {63'd0, CFG_READY}, 64'd1);
    for (int k = 0; k < 7; k++) begin
      if (v[k].flip && !CHK) continue;
      if (v[k].hdr[31:16] != 16'hC7F0) begin
        send(v[k].hdr, 1'b0);
        chk($sformatf("v%0d ERR", k), {63'd0, CFG_ERR}, 64'd1);
        chk($sformatf("v%0d BUSY", k), {63'd0, CFG_BUSY}, 64'd0);
      end else begin
        for (int i = 0; i < 8; i++) w[i] = v[k].ones ? 32'hFFFF_FFFF : 32'(i + 1);
        w[8] = v[k].mw;
        send_frame(v[k].hdr, w, v[k].flip, 1'b0);
        chk($sformatf("v%0d DONE early", k), {63'd0, CFG_DONE}, 64'd0);
        if (v[k].flip) begin
          chk($sformatf("v%0d ERR", k), {63'd0, CFG_ERR}, 64'd1);
          chk($sformatf("v%0d BUSY", k), {63'd0, CFG_BUSY}, 64'd0);
        end else begin
          chk($sformatf("v%0d READY in commit", k), {63'd0, CFG_READY}, 64'd0);
          @(posedge CLK);
          #1 chk($sformatf("v%0d DONE", k), {63'd0, CFG_DONE}, 64'd1);
          chk_outs($sformatf("v%0d at done", k), v[k].a, v[k].b, v[k].c, v[k].d, v[k].m);
        end
      end
      @(posedge CLK);
      #1 chk($sformatf("v%0d DONE after", k), {63'd0, CFG_DONE}, 64'd0);
      chk($sformatf("v%0d ERR after", k), {63'd0, CFG_ERR}, 64'd0);
      chk_outs($sformatf("v%0d", k), v[k].a, v[k].b, v[k].c, v[k].d, v[k].m);
    end
    send(32'hC7F0_001F, 1'b0);
    for (int i = 0; i < 5; i++) send(32'hDEAD_0000 + 32'(i), 1'b0);
    SR_N = 1'b0;
    @(posedge CLK);
    #1 chk_outs("midrst", '0, '0, '0, '0, '0);
    chk("midrst BUSY", {63'd0, CFG_BUSY}, 64'd0);
    chk("midrst READY", {63'd0, CFG_READY}, 64'd0);
    SR_N = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 9; i++) w[i] = 32'h11 + 32'(i);
    send_frame(32'hC7F0_0011, w, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 chk_outs("fresh", 64'h0000_0012_0000_0011, '0, '0, '0, 32'h0000_0019);
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) w[i] = 32'hAAAA_0000 + 32'(i);
    send_frame(32'hC7F0_0003, w, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) w[i] = 32'hBBBB_0000 + 32'(i);
    send_frame(32'hC7F0_0002, w, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 mon_en = 1'b0;
    chk("b2b done count", 64'(dn_cnt), 64'd2);
    chk("b2b READY low cycles", 64'(low_cnt), 64'd2);
    chk("b2b first BLUT", snap_b, 64'hAAAA_0003_AAAA_0002);
    chk_outs("b2b", 64'hAAAA_0001_AAAA_0000, 64'hBBBB_0003_BBBB_0002, '0, '0, 32'h0000_0019);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
